maze_path_checker: RTL and testbench
====================================

Name: maze_path_checker

Overview:
- Drives the other end of the maze-solver serial protocol.
- Holds a 17x17 maze loaded by row writes, then streams it bit-serially to the solver (maze_valid/maze_bit).
- Receives the solver's 2-bit direction stream (dut_out_valid/dut_out) and walks it from (0,0), checking for bounds, walls and reaching (16,16).
- Reports pass/fail, an error code and the step count; used as the self-checking pattern engine in the maze test environment.

Parameters:
- MAZE_WIDTH, 17, maze side length; cells = MAZE_WIDTH*MAZE_WIDTH.
- MAX_LATENCY, 3000, max cycles from last maze bit to first dut_out_valid.
- CNT_WIDTH, 12, width of the latency counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse: begin a run (honoured in IDLE only)
- row_we  in  1  row write enable (honoured in IDLE only)
- row_addr  in  5  row index x, 0..MAZE_WIDTH-1; writes with a larger index are ignored
- row_data  in  MAZE_WIDTH  bit y = cell (x,y); 1 = open, 0 = wall
- busy  out  1  high in any state other than IDLE
- maze_valid  out  1  to solver in_valid
- maze_bit  out  1  to solver in
- dut_out_valid  in  1  from solver out_valid
- dut_out  in  2  from solver out; 0=RIGHT (y+1), 1=DOWN (x+1), 2=LEFT (y-1), 3=UP (x-1)
- done  out  1  one-cycle pulse when the result is valid
- pass  out  1  result, held until next start
- err_code  out  3  0 NONE, 1 WALL, 2 OOB, 3 SHORT, 4 OVERRUN, 5 TIMEOUT, 6 EARLY; held until next start
- step_cnt  out  9  legal steps accepted; held until next start

Behaviour:
- Reset (clk edge with rst=1):
  - state goes to IDLE; all maze cells cleared to 0.
  - busy, maze_valid, maze_bit, done, pass, err_code and step_cnt all go to 0.
  - Reset mid-run aborts the run; maze_valid is low on the following cycle.
- States: IDLE -> SEND -> WAIT -> RECV -> REPORT -> IDLE.
- IDLE:
  - row_we writes row_data into row row_addr.
  - start clears pass, err_code, step_cnt, position (0,0) and the latency counter, then moves to SEND.
  - row_we and start in the same cycle: the write lands first, and the new data is the data sent.
- SEND:
  - start sampled at edge T; maze_valid is high for cycles T+1..T+289.
  - Raster order: x outer, y inner; maze_bit = cell (x,y) from a registered output.
  - After bit (16,16), go to WAIT; maze_valid is low from T+290.
  - dut_out_valid=1 during SEND latches EARLY; SEND still completes, then the block drains.
- WAIT:
  - The latency counter increments each cycle.
  - dut_out_valid=1 moves to RECV, and that beat is checked in the same cycle.
  - When the counter reaches MAX_LATENCY without a beat, latch TIMEOUT and go to REPORT.
- RECV, per beat with dut_out_valid=1, with no error latched yet:
  - Compute the next cell from dut_out.
  - Position already at (16,16): OVERRUN.
  - Next cell out of bounds (<0 or >16): OOB.
  - Next cell is a wall: WALL.
  - Otherwise: update the position and increment step_cnt, saturating at 511.
  - Revisiting cells is legal; the path is not checked for optimality.
- After an error: later beats are ignored (drain); step_cnt freezes.
- Stream end:
  - When dut_out_valid is low in RECV, go to REPORT.
  - If no error is latched: position (16,16) gives pass=1; otherwise latch SHORT.
- Error priority: only the first error latched is kept (sticky).
- REPORT: done=1 for exactly one cycle with final pass/err_code/step_cnt, then IDLE.
- Row writes and start in any non-IDLE state are ignored.
- All outputs are registered.

Decomposition:
- Package maze_pkg holds:
  - MAZE_WIDTH
  - direction encoding (RIGHT/DOWN/LEFT/UP)
  - err_code constants
  - checker state encoding
- Sub-module maze_dir_step (combinational):
  - inputs: x, y, dir
  - outputs: next_x, next_y (6-bit signed) and oob flag
  - shared with the solver-side model.

Test Plan:
- All-open maze; solver sends 16 DOWN then 16 RIGHT -> done=1 for one cycle, pass=1, err_code=0, step_cnt=32; maze_valid high for exactly 289 cycles.
- Row 1 = 0x1FFFE (cell (1,0) wall); first beat DOWN, 5 more beats follow -> err_code=1 (WALL), step_cnt=0, done only after dut_out_valid drops.
- First beat UP -> err_code=2 (OOB), step_cnt=0.
- 31 legal beats ending at (16,15) -> err_code=3 (SHORT), step_cnt=31; 33 beats (32 to goal, then RIGHT) -> err_code=4 (OVERRUN), step_cnt=32.
- MAX_LATENCY=100, solver silent -> done 100 cycles after the last maze bit, err_code=5; dut_out_valid pulsed at SEND cycle 10 -> err_code=6 after the drain.
- rst at SEND cycle 50 -> maze_valid=0 and busy=0 next cycle, maze cleared; reload rows and start -> full 289-bit stream, normal result.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared definitions for the maze test environment.
// Holds the maze geometry, the direction encoding used on the solver
// output stream, the checker result codes and the checker state encoding.
package maze_pkg;

  localparam int MAZE_WIDTH = 17;
  localparam int COORD_W    = 5;
  localparam int STEP_W     = 9;

  localparam logic [COORD_W-1:0] LAST_IDX = COORD_W'(MAZE_WIDTH - 1);

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,   // y+1
    DIR_DOWN  = 2'd1,   // x+1
    DIR_LEFT  = 2'd2,   // y-1
    DIR_UP    = 2'd3    // x-1
  } dir_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_WALL    = 3'd1,
    ERR_OOB     = 3'd2,
    ERR_SHORT   = 3'd3,
    ERR_OVERRUN = 3'd4,
    ERR_TIMEOUT = 3'd5,
    ERR_EARLY   = 3'd6
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RECV   = 3'd3,
    ST_REPORT = 3'd4
  } chk_state_e;

endpackage

// File: rtl/maze_dir_step.sv
// Combinational single-step move: applies one direction to a cell position.
// Coordinates come out signed and one bit wider so a step off either edge
// is visible as a value, and oob flags it directly.
// Ports:
//   x, y           current cell (0..MAZE_WIDTH-1)
//   dir            direction to move
//   next_x, next_y resulting cell, signed
//   oob            next cell lies outside the maze
module maze_dir_step
  import maze_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  dir_e               dir,
  output logic signed [5:0]  next_x,
  output logic signed [5:0]  next_y,
  output logic               oob
);

  localparam logic signed [5:0] MAX_C = 6'(MAZE_WIDTH - 1);

  logic signed [5:0] cur_x;
  logic signed [5:0] cur_y;

  always_comb begin
    cur_x  = signed'({1'b0, x});
    cur_y  = signed'({1'b0, y});
    next_x = cur_x;
    next_y = cur_y;
    case (dir)
      DIR_RIGHT: next_y = cur_y + 6'sd1;
      DIR_DOWN:  next_x = cur_x + 6'sd1;
      DIR_LEFT:  next_y = cur_y - 6'sd1;
      DIR_UP:    next_x = cur_x - 6'sd1;
      default:   next_x = cur_x;
    endcase
    oob = (next_x < 6'sd0) || (next_x > MAX_C) ||
          (next_y < 6'sd0) || (next_y > MAX_C);
  end

endmodule

// File: rtl/maze_path_checker.sv
// Pattern engine for the maze solver: stores a maze loaded by row writes,
// streams it bit-serially to the solver, then walks the solver's direction
// stream from (0,0) and reports pass / error code / accepted step count.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     begin a run (IDLE only)
//   row_we, row_addr, row_data  row write, bit y of row x = cell (x,y), 1 = open
//   busy                      not IDLE
//   maze_valid, maze_bit      serial maze stream to the solver
//   dut_out_valid, dut_out    direction stream from the solver
//   done                      one-cycle result strobe
//   pass, err_code, step_cnt  result, held until the next start
//
// state  | meaning
// IDLE   | accepts row writes and start
// SEND   | streams the 289 maze cells, x outer / y inner
// WAIT   | counts latency until the first solver beat
// RECV   | walks beats; after an error, drains until valid drops
// REPORT | one-cycle done strobe, back to IDLE
module maze_path_checker
  import maze_pkg::*;
#(
  parameter int MAX_LATENCY = 3000,
  parameter int CNT_WIDTH   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  row_we,
  input  logic [4:0]            row_addr,
  input  logic [MAZE_WIDTH-1:0] row_data,
  output logic                  busy,
  output logic                  maze_valid,
  output logic                  maze_bit,
  input  logic                  dut_out_valid,
  input  logic [1:0]            dut_out,
  output logic                  done,
  output logic                  pass,
  output logic [2:0]            err_code,
  output logic [STEP_W-1:0]     step_cnt
);

  chk_state_e state, state_next;

  logic [MAZE_WIDTH-1:0] maze [MAZE_WIDTH];
  logic [COORD_W-1:0]    pos_x, pos_y;
  logic [COORD_W-1:0]    snd_x, snd_y;
  logic [CNT_WIDTH-1:0]  lat_cnt;
  err_e                  err_q;
  logic                  pass_q, busy_q, valid_q, bit_q, done_q;
  logic [STEP_W-1:0]     step_q;

  logic signed [5:0]     nxt_x, nxt_y;
  logic                  nxt_oob;
  logic [COORD_W-1:0]    cell_x, cell_y;
  logic [MAZE_WIDTH-1:0] cell_row;
  logic                  cell_open;
  logic                  at_goal, send_last, lat_expired, beat_live;
  err_e                  beat_err;
  logic [COORD_W-1:0]    snd_nx, snd_ny;

  maze_dir_step u_step (
    .x      (pos_x),
    .y      (pos_y),
    .dir    (dir_e'(dut_out)),
    .next_x (nxt_x),
    .next_y (nxt_y),
    .oob    (nxt_oob)
  );

  always_comb begin
    // Index with a safe cell when out of bounds; the OOB check wins anyway.
    cell_x    = nxt_oob ? '0 : 5'(nxt_x);
    cell_y    = nxt_oob ? '0 : 5'(nxt_y);
    cell_row  = maze[cell_x];
    cell_open = cell_row[cell_y];

    at_goal   = (pos_x == LAST_IDX) && (pos_y == LAST_IDX);
    send_last = (snd_x == LAST_IDX) && (snd_y == LAST_IDX);
    // lat_cnt holds cycles elapsed since the last maze bit, so the window
    // closes once the final allowed cycle passes without a beat.
    lat_expired = (lat_cnt == CNT_WIDTH'(MAX_LATENCY - 1));
    beat_live = dut_out_valid && (err_q == ERR_NONE) &&
                ((state == ST_WAIT) || (state == ST_RECV));

    beat_err = ERR_NONE;
    if (at_goal)         beat_err = ERR_OVERRUN;
    else if (nxt_oob)    beat_err = ERR_OOB;
    else if (!cell_open) beat_err = ERR_WALL;

    snd_nx = (snd_y == LAST_IDX) ? snd_x + 5'd1 : snd_x;
    snd_ny = (snd_y == LAST_IDX) ? '0 : snd_y + 5'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_SEND;
      // An early beat means the solver is already misbehaving: skip the
      // latency window and go straight to draining.
      ST_SEND:   if (send_last)
                   state_next = ((err_q != ERR_NONE) || dut_out_valid) ? ST_RECV : ST_WAIT;
      ST_WAIT:   if (dut_out_valid)    state_next = ST_RECV;
                 else if (lat_expired) state_next = ST_REPORT;
      ST_RECV:   if (!dut_out_valid)   state_next = ST_REPORT;
      ST_REPORT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAZE_WIDTH; i++) maze[i] <= '0;
      pos_x   <= '0;
      pos_y   <= '0;
      snd_x   <= '0;
      snd_y   <= '0;
      lat_cnt <= '0;
      err_q   <= ERR_NONE;
      pass_q  <= 1'b0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      bit_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      busy_q <= (state_next != ST_IDLE);
      done_q <= (state_next == ST_REPORT);
      case (state)
        ST_IDLE: begin
          if (row_we && (row_addr < 5'(MAZE_WIDTH))) maze[row_addr] <= row_data;
          if (start) begin
            pass_q  <= 1'b0;
            err_q   <= ERR_NONE;
            step_q  <= '0;
            pos_x   <= '0;
            pos_y   <= '0;
            lat_cnt <= '0;
            snd_x   <= '0;
            snd_y   <= '0;
            valid_q <= 1'b1;
            // A same-cycle write to row 0 must be visible in the first bit.
            bit_q   <= (row_we && (row_addr == 5'd0)) ? row_data[0] : maze[0][0];
          end
        end
        ST_SEND: begin
          if (dut_out_valid && (err_q == ERR_NONE)) err_q <= ERR_EARLY;
          if (send_last) begin
            valid_q <= 1'b0;
            bit_q   <= 1'b0;
            lat_cnt <= CNT_WIDTH'(1);
          end else begin
            snd_x <= snd_nx;
            snd_y <= snd_ny;
            bit_q <= maze[snd_nx][snd_ny];
          end
        end
        ST_WAIT, ST_RECV: begin
          if (state == ST_WAIT) begin
            lat_cnt <= lat_cnt + 1'b1;
            if (!dut_out_valid && lat_expired) err_q <= ERR_TIMEOUT;
          end
          if (beat_live) begin
            if (beat_err != ERR_NONE) begin
              err_q <= beat_err;
            end else begin
              pos_x <= 5'(nxt_x);
              pos_y <= 5'(nxt_y);
              if (step_q != '1) step_q <= step_q + 1'b1;
            end
          end
          if ((state == ST_RECV) && !dut_out_valid && (err_q == ERR_NONE)) begin
            if (at_goal) pass_q <= 1'b1;
            else         err_q  <= ERR_SHORT;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = busy_q;
  assign maze_valid = valid_q;
  assign maze_bit   = bit_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_code   = err_q;
  assign step_cnt   = step_q;

endmodule

// File: tb/tb_maze_path_checker.sv
module tb_maze_path_checker;
  import maze_pkg::*;

  localparam int LAT = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        row_we = 1'b0;
  logic [4:0]  row_addr = '0;
  logic [16:0] row_data = '0;
  logic        busy, maze_valid, maze_bit;
  logic        dut_out_valid = 1'b0;
  logic [1:0]  dut_out = '0;
  logic        done, pass;
  logic [2:0]  err_code;
  logic [8:0]  step_cnt;

  maze_path_checker #(.MAX_LATENCY(LAT), .CNT_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .start(start), .row_we(row_we), .row_addr(row_addr),
    .row_data(row_data), .busy(busy), .maze_valid(maze_valid), .maze_bit(maze_bit),
    .dut_out_valid(dut_out_valid), .dut_out(dut_out), .done(done), .pass(pass),
    .err_code(err_code), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [16:0] mz [17];
  logic [1:0]  beats [$];

  int vlen, bit_errs, done_cyc, early_done;
  logic got_pass, got_done_after, got_busy_after;
  logic [2:0] got_err;
  logic [8:0] got_step;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input int a, input logic [16:0] d);
    row_we = 1'b1; row_addr = 5'(a); row_data = d;
    tick();
    row_we = 1'b0;
    if (a < 17) mz[a] = d;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 17; i++) mz[i] = '0;
  endtask

  task automatic load_open();
    for (int i = 0; i < 17; i++) write_row(i, 17'h1FFFF);
  endtask

  task automatic push(input logic [1:0] d, input int n);
    for (int i = 0; i < n; i++) beats.push_back(d);
  endtask

  // One full run. early_at/rst_at: SEND bit number at which to pulse
  // dut_out_valid / assert rst (0 = never). we_start drives a row write in
  // the start cycle.
  task automatic run_case(input int early_at, input int rst_at,
                          input bit we_start, input int wa, input logic [16:0] wd);
    int cyc;
    start = 1'b1;
    if (we_start) begin
      row_we = 1'b1; row_addr = 5'(wa); row_data = wd; mz[wa] = wd;
    end
    tick();
    start = 1'b0; row_we = 1'b0;
    vlen = 0; bit_errs = 0; early_done = 0; done_cyc = -1;
    for (int c = 0; c < 400; c++) begin
      if (!maze_valid) break;
      if (maze_bit !== mz[vlen / 17][vlen % 17]) bit_errs++;
      vlen++;
      if (vlen == early_at) dut_out_valid = 1'b1;
      if (vlen == rst_at) rst = 1'b1;
      tick();
      dut_out_valid = 1'b0;
    end
    chk("stream_ends", maze_valid, 0);
    if (rst) begin
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      clear_model();
      beats.delete();
      return;
    end
    foreach (beats[i]) begin
      dut_out_valid = 1'b1;
      dut_out = beats[i];
      if (done) early_done++;
      tick();
    end
    dut_out_valid = 1'b0;
    cyc = 1 + beats.size();
    for (int c = 0; c < LAT + 50; c++) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      tick();
      cyc++;
    end
    got_pass = pass; got_err = err_code; got_step = step_cnt;
    tick();
    got_done_after = done;
    got_busy_after = busy;
    beats.delete();
  endtask

  initial begin
    clear_model();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", maze_valid, 0);
    chk("rst_bit", maze_bit, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_code, 0);
    chk("rst_step", step_cnt, 0);

    // all open, 16 DOWN + 16 RIGHT
    load_open();
    push(2'd1, 16); push(2'd0, 16);
    run_case(0, 0, 0, 0, '0);
    chk("pass_vlen", vlen, 289);
    chk("pass_bits", bit_errs, 0);
    chk("pass_done_cyc", done_cyc, 34);
    chk("pass_pass", got_pass, 1);
    chk("pass_err", got_err, 0);
    chk("pass_step", got_step, 32);
    chk("pass_done_width", got_done_after, 0);
    chk("pass_busy_after", got_busy_after, 0);

    // wall at (1,0): DOWN then 5 more beats
    write_row(1, 17'h1FFFE);
    push(2'd1, 1); push(2'd0, 5);
    run_case(0, 0, 0, 0, '0);
    chk("wall_bits", bit_errs, 0);
    chk("wall_err", got_err, 1);
    chk("wall_step", got_step, 0);
    chk("wall_pass", got_pass, 0);
    chk("wall_no_early_done", early_done, 0);
    chk("wall_done_cyc", done_cyc, 8);

    // first beat UP
    push(2'd3, 1);
    run_case(0, 0, 0, 0, '0);
    chk("oob_err", got_err, 2);
    chk("oob_step", got_step, 0);

    write_row(1, 17'h1FFFF);
    // 31 legal beats ending at (16,15)
    push(2'd1, 16); push(2'd0, 15);
    run_case(0, 0, 0, 0, '0);
    chk("short_err", got_err, 3);
    chk("short_step", got_step, 31);

    // 32 to goal plus one more RIGHT
    push(2'd1, 16); push(2'd0, 17);
    run_case(0, 0, 0, 0, '0);
    chk("overrun_err", got_err, 4);
    chk("overrun_step", got_step, 32);
    chk("overrun_pass", got_pass, 0);

    // 512 legal moves bouncing DOWN/UP: count saturates, ends at (0,0)
    for (int i = 0; i < 256; i++) begin push(2'd1, 1); push(2'd3, 1); end
    run_case(0, 0, 0, 0, '0);
    chk("sat_step", got_step, 511);
    chk("sat_err", got_err, 3);

    // silent solver
    run_case(0, 0, 0, 0, '0);
    chk("timeout_done_cyc", done_cyc, LAT);
    chk("timeout_err", got_err, 5);

    // beat during SEND bit 10
    run_case(10, 0, 0, 0, '0);
    chk("early_vlen", vlen, 289);
    chk("early_err", got_err, 6);
    chk("early_done_cyc", done_cyc, 2);

    // reset during SEND bit 50
    run_case(0, 50, 0, 0, '0);
    chk("rst_mid_vlen", vlen, 50);
    chk("rst_mid_err", err_code, 0);

    // maze must now be all walls
    push(2'd1, 1);
    run_case(0, 0, 0, 0, '0);
    chk("cleared_bits", bit_errs, 0);
    chk("cleared_vlen", vlen, 289);
    chk("cleared_err", got_err, 1);

    // reload; row 0 written in the start cycle with (0,0) closed
    for (int i = 1; i < 17; i++) write_row(i, 17'h1FFFF);
    push(2'd1, 16); push(2'd0, 16);
    run_case(0, 0, 1, 0, 17'h1FFFE);
    chk("reload_vlen", vlen, 289);
    chk("reload_bits", bit_errs, 0);
    chk("reload_pass", got_pass, 1);
    chk("reload_err", got_err, 0);
    chk("reload_step", got_step, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
